// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_pkg
// Description : Shared constants and state encoding for the NTT twiddle
//               loader. Word-address map of the shared BRAM: x region at
//               words 0..63, twiddle matrix at 64..4159, y region at
//               4160..4223.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  localparam int NTT_N       = 64;
  localparam int W_BASE_WORD = 64;
  localparam int Y_BASE_WORD = 4160;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_MULE  = 3'd2,
    S_MULB  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } omega_state_t;

endpackage
`default_nettype wire

// File: rtl/ntt_modmul.sv
`default_nettype none
// ============================================================================
// Module      : ntt_modmul
// Description : Sequential interleaved modular multiplier, result = a*b mod p.
//               Operands are latched on start; done pulses for one cycle
//               exactly DATA_W cycles after start is sampled.
// Ports       : clk, rst (async, active-high), start, a, b, p -> result, done
//               Requires a, b < p.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_modmul
  import ntt_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] p,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_p;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;

  // One bit of the interleaved method: acc <- 2*acc mod p, then optionally
  // acc <- acc + addend mod p. Intermediates never exceed 2p-2, so one
  // conditional subtract per reduction is enough.
  function automatic logic [DATA_W-1:0] interleave_step(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] addend,
    input logic [DATA_W-1:0] modulus,
    input logic              bit_k
  );
    logic [DATA_W:0] p9;
    logic [DATA_W:0] dbl;
    logic [DATA_W:0] red;
    logic [DATA_W:0] sum;
    p9  = {1'b0, modulus};
    dbl = {acc, 1'b0};
    red = (dbl >= p9) ? dbl - p9 : dbl;
    sum = red + (bit_k ? {1'b0, addend} : '0);
    return DATA_W'((sum >= p9) ? sum - p9 : sum);
  endfunction

  // The MSB iteration is folded into the start cycle so the whole product
  // takes exactly DATA_W register updates (start + DATA_W-1 busy cycles).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a    <= a;
        r_p    <= p;
        r_b    <= b << 1;
        r_acc  <= interleave_step('0, a, p, b[DATA_W-1]);
        r_cnt  <= CNT_W'(DATA_W - 2);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= interleave_step(r_acc, r_a, r_p, r_b[DATA_W-1]);
        r_b   <= r_b << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign result = r_acc;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: rtl/ntt_omega_gen.sv
`default_nettype none
// ============================================================================
// Module      : ntt_omega_gen
// Description : Fills the twiddle region of the shared NTT BRAM with
//               w[i][j] = omega^(i*j) mod p, row-major, one 64-bit word per
//               entry at word W_BASE + N*i + j. Each entry costs 9 cycles:
//               one write cycle plus an 8-cycle modular multiply.
// Ports       : clk, rst (async, active-high), start, omega, modulus
//               BRAM_addr (byte address), BRAM_clk, BRAM_din, BRAM_en,
//               BRAM_we, busy, done (sticky), err (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_omega_gen
  import ntt_pkg::*;
#(
  parameter int N      = NTT_N,
  parameter int W_BASE = W_BASE_WORD,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] omega,
  input  logic [DATA_W-1:0] modulus,
  output logic [14:0]       BRAM_addr,
  output logic              BRAM_clk,
  output logic [63:0]       BRAM_din,
  output logic              BRAM_en,
  output logic              BRAM_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                 IDX_W     = $clog2(N);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N - 1);
  localparam logic [14:0]        BASE_BYTE = 15'(W_BASE * 4);
  localparam logic [DATA_W-1:0]  ONE       = DATA_W'(1);

  omega_state_t      r_state;
  omega_state_t      w_state_nxt;
  logic [DATA_W-1:0] r_omega;
  logic [DATA_W-1:0] r_p;
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_base;
  logic [IDX_W-1:0]  r_i;
  logic [IDX_W-1:0]  r_j;
  logic [DATA_W-1:0] w_cur_nxt;
  logic [DATA_W-1:0] w_base_nxt;
  logic [IDX_W-1:0]  w_i_nxt;
  logic [IDX_W-1:0]  w_j_nxt;
  logic              w_latch;
  logic              w_param_bad;
  logic              w_mm_start;
  logic [DATA_W-1:0] w_mm_a;
  logic [DATA_W-1:0] w_mm_b;
  logic [DATA_W-1:0] w_mm_result;
  logic              w_mm_done;
  logic [14:0]       w_addr_nxt;
  logic [14:0]       r_addr;
  logic [63:0]       r_din;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  assign w_param_bad = (modulus < DATA_W'(2)) || (omega >= modulus);

  // Row stride N is a power of two, so N*i + j is just {i, j}.
  assign w_addr_nxt = BASE_BYTE + 15'({w_i_nxt, w_j_nxt, 2'b00});

  ntt_modmul #(
    .DATA_W (DATA_W)
  ) u_modmul (
    .clk    (clk),
    .rst    (rst),
    .start  (w_mm_start),
    .a      (w_mm_a),
    .b      (w_mm_b),
    .p      (r_p),
    .result (w_mm_result),
    .done   (w_mm_done)
  );

  // cur walks along a row (cur *= base), base steps between rows
  // (base *= omega), so base = omega^i and cur = omega^(i*j).
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_base_nxt  = r_base;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_latch     = 1'b0;
    w_mm_start  = 1'b0;
    w_mm_a      = r_cur;
    w_mm_b      = r_base;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (w_param_bad) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_WRITE;
            w_latch     = 1'b1;
            w_cur_nxt   = ONE;
            w_base_nxt  = ONE;
            w_i_nxt     = '0;
            w_j_nxt     = '0;
          end
        end
      end
      S_WRITE: begin
        if (r_j != LAST_IDX) begin
          w_mm_start  = 1'b1;
          w_state_nxt = S_MULE;
        end else if (r_i != LAST_IDX) begin
          w_mm_start  = 1'b1;
          w_mm_a      = r_base;
          w_mm_b      = r_omega;
          w_state_nxt = S_MULB;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_MULE: begin
        if (w_mm_done) begin
          w_cur_nxt   = w_mm_result;
          w_j_nxt     = r_j + 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_MULB: begin
        if (w_mm_done) begin
          w_base_nxt  = w_mm_result;
          w_cur_nxt   = ONE;
          w_i_nxt     = r_i + 1'b1;
          w_j_nxt     = '0;
          w_state_nxt = S_WRITE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Port registers are loaded on the edge that enters WRITE, so address,
  // data and strobe all appear together during the WRITE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_omega <= '0;
      r_p     <= '0;
      r_cur   <= '0;
      r_base  <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_base  <= w_base_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      if (w_latch) begin
        r_omega <= omega;
        r_p     <= modulus;
      end
      r_we <= (w_state_nxt == S_WRITE);
      if (w_state_nxt == S_WRITE) begin
        r_addr <= w_addr_nxt;
        r_din  <= 64'(w_cur_nxt);
      end
      r_busy <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_MULE) ||
                (w_state_nxt == S_MULB);
      r_done <= (w_state_nxt == S_DONE);
      r_err  <= (w_state_nxt == S_ERR);
    end
  end

  assign BRAM_clk  = clk;
  assign BRAM_addr = r_addr;
  assign BRAM_din  = r_din;
  assign BRAM_we   = r_we;
  assign BRAM_en   = r_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ntt_omega_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_omega_gen
// Description : Self-checking bench for ntt_omega_gen and its ntt_modmul.
//               A write monitor scores every BRAM write against
//               omega^(i*j) mod p computed with plain modular exponentiation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_omega_gen;
  import ntt_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  omega = 8'd0;
  logic [7:0]  modulus = 8'd0;
  logic [14:0] BRAM_addr;
  logic        BRAM_clk;
  logic [63:0] BRAM_din;
  logic        BRAM_en;
  logic        BRAM_we;
  logic        busy;
  logic        done;
  logic        err;

  logic        mm_start = 1'b0;
  logic [7:0]  mm_a = 8'd0;
  logic [7:0]  mm_b = 8'd0;
  logic [7:0]  mm_p = 8'd2;
  logic [7:0]  mm_result;
  logic        mm_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int run_c0 = 0;
  int wr_count = 0;
  bit run_active = 1'b0;
  int cur_om = 0;
  int cur_p = 2;
  logic [63:0] mem [0:4223];

  ntt_omega_gen u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .omega     (omega),
    .modulus   (modulus),
    .BRAM_addr (BRAM_addr),
    .BRAM_clk  (BRAM_clk),
    .BRAM_din  (BRAM_din),
    .BRAM_en   (BRAM_en),
    .BRAM_we   (BRAM_we),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  ntt_modmul u_mm (
    .clk    (clk),
    .rst    (rst),
    .start  (mm_start),
    .a      (mm_a),
    .b      (mm_b),
    .p      (mm_p),
    .result (mm_result),
    .done   (mm_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int modpow(input int b, input int e, input int m);
    longint r;
    longint x;
    int     ee;
    r  = 1;
    x  = b % m;
    ee = e;
    while (ee > 0) begin
      if (ee % 2 == 1) r = (r * x) % m;
      x  = (x * x) % m;
      ee = ee / 2;
    end
    return int'(r % m);
  endfunction

  // Write monitor / scoreboard: write k must land at word 64+k in cycle 1+9k.
  always @(posedge clk) begin
    #1;
    if (BRAM_we) begin : mon
      int k;
      int word;
      chk("en_eq_we", 64'(BRAM_en), 64'(1));
      chk("addr_bounds", 64'(BRAM_addr >= 15'd256 && BRAM_addr <= 15'd16636 &&
                             BRAM_addr[1:0] == 2'b00), 64'(1));
      word = int'(BRAM_addr) / 4;
      if (word < 4224) mem[word] = BRAM_din;
      if (!run_active || wr_count >= 4096) begin
        chk("stray_write", 64'(BRAM_we), 64'(0));
      end else begin
        k = wr_count;
        chk("wr_addr", 64'(BRAM_addr), 64'((64 + k) * 4));
        chk("wr_data", BRAM_din, 64'(modpow(cur_om, (k / 64) * (k % 64), cur_p)));
        chk("wr_cycle", 64'(cyc - run_c0), 64'(1 + 9 * k));
      end
      wr_count++;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},   64'(BRAM_we),   64'(0));
    chk({tag, "_en"},   64'(BRAM_en),   64'(0));
    chk({tag, "_addr"}, 64'(BRAM_addr), 64'(0));
    chk({tag, "_din"},  BRAM_din,       64'(0));
    chk({tag, "_busy"}, 64'(busy),      64'(0));
    chk({tag, "_done"}, 64'(done),      64'(0));
    chk({tag, "_err"},  64'(err),       64'(0));
  endtask

  task automatic mm_check(input int a, input int b, input int p);
    int c0;
    @(negedge clk);
    mm_a = 8'(a); mm_b = 8'(b); mm_p = 8'(p); mm_start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    mm_start = 1'b0;
    mm_a = 8'($urandom); mm_b = 8'($urandom); mm_p = 8'($urandom);
    while (!mm_done && (cyc - c0) < 20) @(negedge clk);
    chk("mm_latency", 64'(cyc - c0), 64'(8));
    chk("mm_result", 64'(mm_result), 64'((a * b) % p));
    @(negedge clk);
    chk("mm_done_pulse", 64'(mm_done), 64'(0));
  endtask

  task automatic err_check(input int om, input int p);
    int w0;
    w0 = wr_count;
    @(negedge clk);
    omega = 8'(om); modulus = 8'(p); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_flag", 64'(err), 64'(1));
    chk("err_busy", 64'(busy), 64'(0));
    chk("err_done", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    chk("err_busy_later", 64'(busy), 64'(0));
    chk("err_nowrites", 64'(wr_count), 64'(w0));
  endtask

  task automatic start_run(input int om, input int p);
    @(negedge clk);
    omega = 8'(om); modulus = 8'(p); start = 1'b1;
    cur_om = om; cur_p = p; run_c0 = cyc; wr_count = 0; run_active = 1'b1;
    @(negedge clk);
    start = 1'b0;
    omega = 8'($urandom); modulus = 8'($urandom);
  endtask

  task automatic wait_rel(input int r);
    while ((cyc - run_c0) < r) @(negedge clk);
  endtask

  initial begin
    int p;
    int om;
    int lim;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("bram_clk", 64'(BRAM_clk), 64'(clk));
    rst = 1'b0;

    // Standalone multiplier: fixed corners then random operands
    mm_check(200, 250, 251);
    mm_check(0, 123, 251);
    mm_check(77, 1, 101);
    for (int n = 0; n < 8; n++) begin
      p = $urandom_range(255, 2);
      mm_check($urandom_range(p - 1, 0), $urandom_range(p - 1, 0), p);
    end

    // Invalid parameters from IDLE / ERR
    err_check(0, 1);
    err_check(0, 0);
    err_check(17, 17);
    for (int n = 0; n < 3; n++) begin
      p = $urandom_range(255, 0);
      om = (p < 2) ? $urandom_range(255, 0) : $urandom_range(255, p);
      err_check(om, p);
    end

    // Full run omega=3, p=17 with a start pulse during write 5
    start_run(3, 17);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("err_cleared", 64'(err), 64'(0));
    wait_rel(46);
    start = 1'b1; omega = 8'd5; modulus = 8'd7;
    @(negedge clk);
    start = 1'b0;
    lim = 0;
    while (!done && lim < 40000) begin
      @(negedge clk);
      lim++;
    end
    chk("done_cycle", 64'(cyc - run_c0), 64'(36857));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("err_at_done", 64'(err), 64'(0));
    chk("write_count", 64'(wr_count), 64'(4096));
    chk("w64", mem[64], 64'(1));
    chk("w129", mem[129], 64'(3));
    chk("w130", mem[130], 64'(9));
    chk("w195", mem[195], 64'(15));
    chk("w144", mem[144], 64'(1));
    chk("w4159", mem[4159], 64'(3));
    repeat (5) @(negedge clk);
    chk("done_sticky", 64'(done), 64'(1));
    chk("count_stable", 64'(wr_count), 64'(4096));

    // Second run from DONE (omega=4), then reset between writes 100 and 101
    start_run(4, 17);
    chk("done_cleared", 64'(done), 64'(0));
    chk("busy_run2", 64'(busy), 64'(1));
    wait_rel(600);
    chk("w130_omega4", mem[130], 64'(16));
    wait_rel(902);
    #2;
    run_active = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midrun_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_writes_after_rst", 64'(wr_count), 64'(101));
    check_all_zero("post_rst");

    // Restart with random valid parameters
    p  = $urandom_range(255, 2);
    om = $urandom_range(p - 1, 0);
    mem[64] = '1;
    start_run(om, p);
    wait_rel(1 + 9 * 150 + 1);
    chk("restart_w64", mem[64], 64'(1));
    chk("restart_count", 64'(wr_count), 64'(151));
    chk("restart_busy", 64'(busy), 64'(1));

    run_active = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
